plru_tree: RTL and testbench
============================

PLRU_TREE -- requirements
Module: plru_tree

Interface
REQ-001 Parameter WAYS, default 8: associativity; power of two, 2..16.
REQ-002 Parameter SETS, default 4: independent PLRU trees; power of two, 1..256; SET_W = max(1, log2(SETS)).
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 acc_valid  input  1  hit/touch request this cycle.
REQ-006 acc_set  input  SET_W  set index of the touch.
REQ-007 acc_way  input  WAYS  one-hot touched way; all-zero means no update.
REQ-008 alc_valid  input  1  allocation (replacement) request this cycle.
REQ-009 alc_set  input  SET_W  set index of the allocation.
REQ-010 valid_mask  input  WAYS  per-way line-valid bits of alc_set.
REQ-011 lock_mask  input  WAYS  per-way lock bits; a locked way is never chosen as victim.
REQ-012 inv_all  input  1  clears every tree to the reset state.
REQ-013 victim  output  WAYS  one-hot victim way, combinational, same cycle as alc_valid.
REQ-014 alc_fail  output  1  allocation found no eligible way, combinational.

Function
REQ-015 Each set holds WAYS-1 state bits in heap order: node 0 is the root; node i has children 2i+1 (lower ways) and 2i+2 (upper ways); the last level selects adjacent way pairs (0,1), (2,3), and so on.
REQ-016 Node bit 0 points the replacement walk to the lower subtree; bit 1 points it to the upper subtree.
REQ-017 victim = 0 and alc_fail = 0 whenever alc_valid = 0.
REQ-018 With alc_valid = 1, eligible ways are ~lock_mask.
REQ-019 If any eligible way has valid_mask = 0, victim is the lowest-indexed eligible invalid way; the tree is ignored.
REQ-020 Otherwise victim comes from a tree walk from the root: follow the node bit, but if the pointed subtree contains no eligible way, take the other subtree.
REQ-021 If no way is eligible (lock_mask all ones), victim = 0, alc_fail = 1, and the trees are not updated.
REQ-022 On a successful allocation, at the next edge every node on the victim's path is set to point away from the victim; all other nodes are unchanged.
REQ-023 On acc_valid with a non-zero acc_way, at the next edge every node on that way's path is set to point away from it.
REQ-024 Touch and allocation to different sets in the same cycle both update their sets.
REQ-025 Touch and allocation to the same set in the same cycle: only the allocation update is applied.
REQ-026 inv_all has priority over touch and allocation: all bits become 0 at the next edge. victim and alc_fail are still computed from the current state.
REQ-027 A touch to a way that is already LRU-opposite leaves the set unchanged (idempotent).
REQ-028 acc_way with more than one bit set is illegal; the bench asserts it never occurs, and RTL behaviour is undefined.
REQ-029 Out-of-range set indices cannot occur because SETS is a power of two.

Reset
REQ-030 rst_n low asynchronously clears all SETS*(WAYS-1) state bits to 0.
REQ-031 Outputs during reset depend only on the inputs: victim = 0 and alc_fail = 0 when alc_valid = 0.
REQ-032 A reset asserted mid-operation discards pending updates; the first allocation after release with all ways valid and unlocked returns way 0.

Structure
REQ-033 The shared package holds the WAYS/SETS legality checks, the SET_W derivation, and the helper that computes node-index paths.
REQ-034 One combinational sub-module, plru_tree_pick, performs the eligible-aware tree walk for a single tree and returns a one-hot way.
REQ-035 The top level holds the state array, the per-set update decode, the invalid-first selection and the priority rules.

Verification (WAYS=8, SETS=4)
REQ-036 After reset, four successive allocations to set 0 (all valid, no locks) -> victims 0x01, 0x10, 0x04, 0x40.
REQ-037 After reset, touch way 0 in set 1, then allocate set 1 -> victim 0x10; an allocation to set 2 still gives 0x01.
REQ-038 Allocate with valid_mask 0xFB -> victim 0x04 and set state unchanged; with lock_mask 0x04 added -> victim 0x01 (tree walk).
REQ-039 After reset, lock_mask 0x0F -> victim 0x10; lock_mask 0xFF -> victim 0x00, alc_fail = 1, and the next unlocked allocation gives 0x01.
REQ-040 Same-cycle touch way 4 and allocation in set 0 -> victim 0x01; the next allocation gives 0x10 (touch dropped).
REQ-041 Perform three allocations, then pulse inv_all together with an allocation -> next allocation returns 0x01; rst_n asserted mid-sequence gives the same result.

Source files
------------

// File: rtl/plru_tree_pkg.sv
// Shared definitions for the tree-PLRU replacement block.
// Holds the parameter legality checks, the set-index width derivation and
// the helpers that map a way and a tree level onto a heap node index.
package plru_tree_pkg;

  function automatic bit is_pow2(input int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

  function automatic bit ways_legal(input int unsigned ways);
    return is_pow2(ways) && (ways >= 2) && (ways <= 16);
  endfunction

  function automatic bit sets_legal(input int unsigned sets);
    return is_pow2(sets) && (sets >= 1) && (sets <= 256);
  endfunction

  // A single set still gets a 1-bit index so the ports never collapse.
  function automatic int unsigned set_width(input int unsigned sets);
    return (sets <= 2) ? 1 : $clog2(sets);
  endfunction

  // Heap index of the node that way 'way' passes through at 'level' (root = 0).
  function automatic int unsigned path_node(input int unsigned way,
                                            input int unsigned level,
                                            input int unsigned levels);
    return ((32'd1 << level) - 32'd1) + (way >> (levels - level));
  endfunction

  // 1 when the way lies in the upper subtree of its node at 'level'.
  function automatic bit path_upper(input int unsigned way,
                                    input int unsigned level,
                                    input int unsigned levels);
    return 1'((way >> (levels - 32'd1 - level)) & 32'd1);
  endfunction

endpackage

// File: rtl/plru_tree_pick.sv
// Eligible-aware walk of one PLRU tree.
// Ports: tree     - WAYS-1 node bits in heap order (1 = go to upper subtree)
//        eligible - ways that may be chosen
//        way_c    - one-hot chosen way, zero when nothing is eligible
module plru_tree_pick #(
  parameter int unsigned WAYS = 8
) (
  input  logic [WAYS-2:0] tree,
  input  logic [WAYS-1:0] eligible,
  output logic [WAYS-1:0] way_c
);

  localparam int unsigned LEVELS = $clog2(WAYS);

  // Follow the node bit unless that side has no eligible way.
  always_comb begin
    int unsigned node;
    int unsigned base;
    int unsigned half;
    logic        lo_any;
    logic        hi_any;
    logic        go_up;
    node   = 0;
    base   = 0;
    half   = WAYS;
    lo_any = 1'b0;
    hi_any = 1'b0;
    go_up  = 1'b0;
    for (int unsigned l = 0; l < LEVELS; l++) begin
      half   = half >> 1;
      lo_any = 1'b0;
      hi_any = 1'b0;
      for (int unsigned w = 0; w < WAYS; w++) begin
        if ((w >= base) && (w < base + half)) begin
          lo_any = lo_any | eligible[w];
        end else if ((w >= base + half) && (w < base + 2 * half)) begin
          hi_any = hi_any | eligible[w];
        end
      end
      go_up = 1'(tree >> node);
      if (go_up && !hi_any) begin
        go_up = 1'b0;
      end else if (!go_up && !lo_any) begin
        go_up = 1'b1;
      end
      if (go_up) begin
        base = base + half;
      end
      node = 2 * node + 1 + 32'(go_up);
    end
    way_c = (|eligible) ? (WAYS'(1) << base) : '0;
  end

endmodule

// File: rtl/plru_tree.sv
// Multi-set tree pseudo-LRU replacement state with lock and invalid-first
// victim selection.
// Ports: clk, rst_n (async, active-low)
//        acc_valid/acc_set/acc_way       - touch (hit) of a one-hot way
//        alc_valid/alc_set               - allocation request
//        valid_mask/lock_mask            - line-valid and lock bits of alc_set
//        inv_all                         - clear every tree
//        victim/alc_fail                 - combinational allocation result
module plru_tree
  import plru_tree_pkg::*;
#(
  parameter int unsigned WAYS = 8,
  parameter int unsigned SETS = 4,
  localparam int unsigned SET_W = set_width(SETS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             acc_valid,
  input  logic [SET_W-1:0] acc_set,
  input  logic [WAYS-1:0]  acc_way,
  input  logic             alc_valid,
  input  logic [SET_W-1:0] alc_set,
  input  logic [WAYS-1:0]  valid_mask,
  input  logic [WAYS-1:0]  lock_mask,
  input  logic             inv_all,
  output logic [WAYS-1:0]  victim,
  output logic             alc_fail
);

  localparam int unsigned NODES  = WAYS - 1;
  localparam int unsigned LEVELS = $clog2(WAYS);

  if (!ways_legal(WAYS)) begin : g_bad_ways
    $error("plru_tree: WAYS must be a power of two in 2..16");
  end
  if (!sets_legal(SETS)) begin : g_bad_sets
    $error("plru_tree: SETS must be a power of two in 1..256");
  end

  logic [NODES-1:0] tree_q [SETS];
  logic [NODES-1:0] alc_tree;
  logic [NODES-1:0] acc_tree;
  logic [NODES-1:0] alc_next;
  logic [NODES-1:0] acc_next;
  logic [WAYS-1:0]  eligible;
  logic [WAYS-1:0]  inv_elig;
  logic [WAYS-1:0]  inv_pick;
  logic [WAYS-1:0]  walk_pick;
  logic             alc_upd;
  logic             acc_upd;

  // Point every node on the way's path away from that way.
  function automatic logic [NODES-1:0] touch(input logic [NODES-1:0] t,
                                             input logic [WAYS-1:0]  oh);
    logic [NODES-1:0] r;
    int unsigned      w;
    int unsigned      n;
    r = t;
    w = 0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (oh[i]) w = i;
    end
    for (int unsigned l = 0; l < LEVELS; l++) begin
      n = path_node(w, l, LEVELS);
      if (path_upper(w, l, LEVELS)) r = r & ~(NODES'(1) << n);
      else                          r = r | (NODES'(1) << n);
    end
    return r;
  endfunction

  assign alc_tree = tree_q[alc_set];
  assign acc_tree = tree_q[acc_set];
  assign eligible = ~lock_mask;
  assign inv_elig = eligible & ~valid_mask;
  // Isolate the lowest set bit: lowest-indexed eligible invalid way.
  assign inv_pick = inv_elig & (~inv_elig + WAYS'(1));

  plru_tree_pick #(.WAYS(WAYS)) u_pick (
    .tree     (alc_tree),
    .eligible (eligible),
    .way_c    (walk_pick)
  );

  // Victim select: no eligible way fails, invalid lines win over the tree.
  always_comb begin
    victim   = '0;
    alc_fail = 1'b0;
    if (alc_valid) begin
      if (~|eligible) begin
        alc_fail = 1'b1;
      end else if (|inv_elig) begin
        victim = inv_pick;
      end else begin
        victim = walk_pick;
      end
    end
  end

  // Invalid-way fills leave the tree alone; only tree-walk victims age it.
  // An allocation to a set suppresses a same-cycle touch of that set.
  assign alc_upd  = alc_valid & (|eligible) & ~(|inv_elig);
  assign acc_upd  = acc_valid & (|acc_way) & ~(alc_valid & (acc_set == alc_set));
  assign alc_next = touch(alc_tree, walk_pick);
  assign acc_next = touch(acc_tree, acc_way);

  // Per-set state update with inv_all taking priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < SETS; s++) tree_q[s] <= '0;
    end else if (inv_all) begin
      for (int unsigned s = 0; s < SETS; s++) tree_q[s] <= '0;
    end else begin
      for (int unsigned s = 0; s < SETS; s++) begin
        if (alc_upd && (alc_set == SET_W'(s))) begin
          tree_q[s] <= alc_next;
        end else if (acc_upd && (acc_set == SET_W'(s))) begin
          tree_q[s] <= acc_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_plru_tree.sv
// Self-checking bench for plru_tree (WAYS=8, SETS=4): directed scenarios
// with fixed expected victims plus randomized traffic against a
// range-based reference model of the replacement trees.
module tb_plru_tree;

  logic       clk;
  logic       rst_n;
  logic       acc_valid;
  logic [1:0] acc_set;
  logic [7:0] acc_way;
  logic       alc_valid;
  logic [1:0] alc_set;
  logic [7:0] valid_mask;
  logic [7:0] lock_mask;
  logic       inv_all;
  logic [7:0] victim;
  logic       alc_fail;

  int total = 0;
  int bad   = 0;

  // Reference state: per set, per heap node, 1 = replacement goes upper.
  bit m [4][7];

  plru_tree #(.WAYS(8), .SETS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .acc_valid  (acc_valid),
    .acc_set    (acc_set),
    .acc_way    (acc_way),
    .alc_valid  (alc_valid),
    .alc_set    (alc_set),
    .valid_mask (valid_mask),
    .lock_mask  (lock_mask),
    .inv_all    (inv_all),
    .victim     (victim),
    .alc_fail   (alc_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int s = 0; s < 4; s++)
      for (int n = 0; n < 7; n++) m[s][n] = 1'b0;
  endtask

  // Walk the way range [lo, lo+size) halving each level.
  function automatic int model_walk(input int s, input logic [7:0] elig);
    int lo, size, n, half;
    bit lo_ok, hi_ok, up;
    lo = 0; size = 8; n = 0;
    while (size > 1) begin
      half = size / 2;
      lo_ok = 1'b0; hi_ok = 1'b0;
      for (int w = 0; w < 8; w++) begin
        if (w >= lo && w < lo + half && elig[w]) lo_ok = 1'b1;
        if (w >= lo + half && w < lo + size && elig[w]) hi_ok = 1'b1;
      end
      up = m[s][n];
      if (up && !hi_ok) up = 1'b0;
      else if (!up && !lo_ok) up = 1'b1;
      if (up) lo = lo + half;
      n = 2 * n + 1 + int'(up);
      size = half;
    end
    return lo;
  endfunction

  task automatic model_touch(input int s, input int way);
    int lo, size, n, half;
    bit up;
    lo = 0; size = 8; n = 0;
    while (size > 1) begin
      half = size / 2;
      up = (way >= lo + half);
      m[s][n] = !up;
      if (up) lo = lo + half;
      n = 2 * n + 1 + int'(up);
      size = half;
    end
  endtask

  function automatic int onehot_idx(input logic [7:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < 8; i++) if (oh[i]) r = i;
    return r;
  endfunction

  task automatic idle();
    acc_valid = 1'b0; acc_set = 2'd0; acc_way = 8'h00;
    alc_valid = 1'b0; alc_set = 2'd0;
    valid_mask = 8'hFF; lock_mask = 8'h00; inv_all = 1'b0;
  endtask

  // Check current outputs against the model (and optional constants), then
  // advance one edge and update the model the same way.
  task automatic step(input string tag, input bit has_exp,
                      input logic [7:0] ev, input logic ef);
    logic [7:0] mv;
    logic       mf;
    logic [7:0] elig;
    logic [7:0] free;
    bit         walked;
    #1;
    assert ($onehot0(acc_way)) else $error("illegal multi-hot acc_way");
    elig = ~lock_mask;
    free = elig & ~valid_mask;
    mv = 8'h00; mf = 1'b0; walked = 1'b0;
    if (alc_valid) begin
      if (elig == 8'h00) begin
        mf = 1'b1;
      end else if (free != 8'h00) begin
        for (int i = 7; i >= 0; i--) if (free[i]) mv = 8'h01 << i;
      end else begin
        mv = 8'h01 << model_walk(int'(alc_set), elig);
        walked = 1'b1;
      end
    end
    chk({tag, "_victim"}, victim, mv);
    chk({tag, "_fail"}, {7'd0, alc_fail}, {7'd0, mf});
    if (has_exp) begin
      chk({tag, "_victim_spec"}, victim, ev);
      chk({tag, "_fail_spec"}, {7'd0, alc_fail}, {7'd0, ef});
    end
    if (inv_all) begin
      clear_model();
    end else begin
      if (walked) model_touch(int'(alc_set), onehot_idx(mv));
      if (acc_valid && acc_way != 8'h00 && !(alc_valid && alc_set == acc_set))
        model_touch(int'(acc_set), onehot_idx(acc_way));
    end
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_model();
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input string tag, input logic [1:0] s, input logic [7:0] ev);
    alc_valid = 1'b1; alc_set = s;
    step(tag, 1'b1, ev, 1'b0);
  endtask

  initial begin
    logic [7:0] seq36 [4];
    seq36[0] = 8'h01; seq36[1] = 8'h10; seq36[2] = 8'h04; seq36[3] = 8'h40;
    idle();
    clear_model();
    rst_n = 1'b0;
    #12;
    // Outputs during reset follow the inputs.
    chk("rst_idle_victim", victim, 8'h00);
    chk("rst_idle_fail", {7'd0, alc_fail}, 8'h00);
    alc_valid = 1'b1;
    #1;
    chk("rst_alloc_victim", victim, 8'h01);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Successive allocations rotate through the tree.
    for (int i = 0; i < 4; i++) alloc($sformatf("seq36_%0d", i), 2'd0, seq36[i]);

    // A touch ages only its own set.
    do_reset();
    acc_valid = 1'b1; acc_set = 2'd1; acc_way = 8'h01;
    step("touch37", 1'b0, 8'h00, 1'b0);
    alloc("alloc37_s1", 2'd1, 8'h10);
    alloc("alloc37_s2", 2'd2, 8'h01);

    // Invalid-first fill leaves the tree untouched.
    do_reset();
    valid_mask = 8'hFB;
    alloc("inv38", 2'd0, 8'h04);
    valid_mask = 8'hFB; lock_mask = 8'h04;
    alloc("walk38", 2'd0, 8'h01);

    // Locks steer the walk; a fully locked set fails without updating.
    do_reset();
    lock_mask = 8'h0F;
    alloc("lock39", 2'd0, 8'h10);
    lock_mask = 8'hFF; alc_valid = 1'b1; alc_set = 2'd0;
    step("lockall39", 1'b1, 8'h00, 1'b1);
    alloc("after39", 2'd0, 8'h01);

    // Same-set touch is dropped in favour of the allocation.
    do_reset();
    acc_valid = 1'b1; acc_set = 2'd0; acc_way = 8'h10;
    alloc("same40", 2'd0, 8'h01);
    alloc("next40", 2'd0, 8'h10);

    // inv_all wins over a same-cycle allocation.
    do_reset();
    alloc("pre41_0", 2'd0, 8'h01);
    alloc("pre41_1", 2'd0, 8'h10);
    alloc("pre41_2", 2'd0, 8'h04);
    inv_all = 1'b1;
    alloc("inv41", 2'd0, 8'h40);
    alloc("post41", 2'd0, 8'h01);

    // Asynchronous reset pulse between edges discards the history.
    alloc("pre41r_0", 2'd0, 8'h10);
    alloc("pre41r_1", 2'd0, 8'h04);
    rst_n = 1'b0;
    clear_model();
    #2;
    rst_n = 1'b1;
    alloc("post41r", 2'd0, 8'h01);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      acc_valid  = 1'($urandom_range(0, 1));
      acc_set    = 2'($urandom_range(0, 3));
      acc_way    = ($urandom_range(0, 8) == 8) ? 8'h00 : (8'h01 << $urandom_range(0, 7));
      alc_valid  = 1'($urandom_range(0, 1));
      alc_set    = 2'($urandom_range(0, 3));
      valid_mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      case ($urandom_range(0, 9))
        0, 1:    lock_mask = 8'($urandom);
        2:       lock_mask = 8'hFF;
        default: lock_mask = 8'h00;
      endcase
      inv_all    = ($urandom_range(0, 39) == 0);
      step("rnd", 1'b0, 8'h00, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
